seqdec_byte_serializer: RTL and testbench
=========================================

# seqdec_byte_serializer

Upstream feeder for the serial sequence detector `seqdec_45`. It accepts parallel bytes over a valid/ready handshake and buffers them in a small FIFO. It shifts each byte out MSB-first, one bit per clock, on a single-bit line that drives the detector's `Inp`. Back-to-back bytes are serialized with no gap, so a continuous bit stream such as a 128-bit test sequence arrives at the detector unbroken.

## Interface
- `WIDTH`, 8, bits per parallel word; also the shift length.
- `DEPTH`, 4, FIFO entries; power of two, ≥ 2.
- `Clk` input 1: single clock; all state updates on its rising edge.
- `Reset` input 1: asynchronous, active-high; clears all state immediately.
- `Data` input WIDTH: parallel word; sampled on accept.
- `Valid` input 1: `Data` is valid.
- `Ready` output 1: FIFO can accept; `Ready = !full`.
- `Ser` output 1: serial bit to the detector's `Inp`; 0 when idle.
- `SerValid` output 1: `Ser` carries a real data bit this cycle.
- `WordDone` output 1: one-cycle pulse while the last bit (LSB) of a word is on `Ser`.
- `Level` output $clog2(DEPTH)+1: current FIFO occupancy.

## Operation
- **Accept:** `Valid && Ready` at a rising edge writes `Data` into the FIFO tail. `Valid` with `!Ready` is ignored; the producer holds `Data` until accepted.
- **Shifter state:** `shreg[WIDTH-1:0]` plus bit counter `cnt`, width $clog2(WIDTH); `Ser = shreg[WIDTH-1]` when in SHIFT, else 0.
- **FSM, IDLE:**
  - `SerValid=0`, `Ser=0`.
  - If FIFO non-empty: pop head into `shreg`, `cnt<=0`, go to SHIFT.
- **FSM, SHIFT:**
  - `SerValid=1`.
  - Each edge: `shreg <= shreg<<1`, `cnt <= cnt+1`.
  - When `cnt==WIDTH-1`, `WordDone=1`. At that edge:
    - FIFO non-empty: pop next word into `shreg`, `cnt<=0`, stay in SHIFT (zero-gap).
    - FIFO empty: go to IDLE.
- **Counter wrap:** `cnt` wraps `WIDTH-1`→0 only via reload; it never free-runs in IDLE.
- **Simultaneous push and pop:**
  - Legal whenever `!full`; `Level` is unchanged.
  - When full, a pop frees space, but `Ready` stays registered low for that cycle. No push-while-full bypass.
- **Empty FIFO, push in IDLE:** the word is written that edge; the shifter loads on the following edge. There is no same-cycle bypass.
- **Reset (any time, including mid-word):** state→IDLE, FIFO pointers→0, `shreg`→0, `cnt`→0. The partial word and buffered words are discarded.
- **Reset values:** `Ready=1`, `Ser=0`, `SerValid=0`, `WordDone=0`, `Level=0`.

## Timing
- **Latency:** word accepted at edge N with an idle, empty block → loaded at edge N+1. Its MSB is on `Ser` during cycle N+1..N+2 and its LSB during N+8..N+9 (WIDTH=8).
- **Throughput:** one bit per clock sustained while the FIFO never runs empty.
- **Signal sources:**
  - `Ready` and `Level` are registered from pointers.
  - `Ser`, `SerValid` and `WordDone` are decoded from state/`shreg`/`cnt` with no combinational path from `Valid` or `Data`.
- **Consumer sampling:** the consumer samples `Ser` on the rising edge. `seqdec_45` therefore sees the bit one edge after it appears.

## Structure
- **Package `seqdec_pkg`:**
  - state enum {IDLE, SHIFT}
  - default `WIDTH`/`DEPTH` constants
  - `MATCH_BYTE = 8'h45`, for bench reuse
- **Sub-module `byte_fifo`:**
  - parameterized WIDTH/DEPTH synchronous FIFO with async reset
  - wrap-bit pointers
  - `full`/`empty`/`level`
- **Top module:** FSM, shift register, counter, handshake glue.

## Test plan
- **Reset values:** assert `Reset` mid-cycle → outputs go to reset values immediately, asynchronously. Release, hold `Valid=0` for 5 cycles → `SerValid=0`, `Ser=0`, `Ready=1`, `Level=0`.
- **Single word:** push 0x45 at edge N → `Ser` = 0,1,0,0,0,1,0,1 across cycles N+1..N+8. `WordDone` is high only in the last of these cycles. Then `SerValid=0`.
- **Back-to-back stream:** hold `Valid=1` with bytes 26,A3,52,F5,45,97,93,45,78 → `SerValid` is high for 72 consecutive cycles and the `Ser` stream equals the bytes MSB-first. `WordDone` pulses every 8th cycle.
- **Backpressure:** push 6 words while the first is shifting, `DEPTH=4` → `Ready` drops when `Level=4`. The 6th word is held by the producer and accepted once a pop occurs. No word is lost or duplicated.
- **Reset mid-word:** assert `Reset` after 3 bits of 0xAB with 2 words buffered → `SerValid` drops at once, `Level=0`. The next pushed 0x26 serializes correctly from its MSB.
- **Integration:** drive `seqdec_45` `Inp` from `Ser` with the stream 00,26,A3,52,F5,45,97,93,45,78,26,A5,29,37,82,AB → detector `Out` pulses exactly once per completed 0x45 window in the bit stream. No pulse appears during idle zeros.

Source files
------------

// File: rtl/seqdec_pkg.sv
// Shared types and constants for the seqdec byte serializer slice.
package seqdec_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_e;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 4;

    localparam logic [7:0] MATCH_BYTE = 8'h45;

endpackage

// File: rtl/seqdec_byte_serializer_byte_fifo.sv
// Synchronous FIFO with wrap-bit pointers; full/empty/level decoded
// straight from the pointer flops.
module byte_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_q, wr_d;
    logic [AW:0]      rd_q, rd_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push_ok;
    logic             pop_ok;

    assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign empty = (wr_q == rd_q);
    assign level = wr_q - rd_q;
    assign rdata = mem_q[rd_q[AW-1:0]];

    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (push_ok) begin
            wr_d = wr_q + {{AW{1'b0}}, 1'b1};
        end
        if (pop_ok) begin
            rd_d = rd_q + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Storage needs no reset: entries are only visible between the pointers.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_q[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/seqdec_byte_serializer.sv
// Parallel-to-serial feeder: buffers bytes and shifts them out MSB-first
// with no gap between back-to-back words.
module seqdec_byte_serializer
    import seqdec_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic [WIDTH-1:0]       Data,
    input  logic                   Valid,
    output logic                   Ready,
    output logic                   Ser,
    output logic                   SerValid,
    output logic                   WordDone,
    output logic [$clog2(DEPTH):0] Level
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    ser_state_e       state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             fifo_full;
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_rdata;
    logic             fifo_pop;
    logic             fifo_push;

    assign Ready     = !fifo_full;
    assign fifo_push = Valid && !fifo_full;

    byte_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (Clk),
        .rst   (Reset),
        .push  (fifo_push),
        .wdata (Data),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (Level)
    );

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
        fifo_pop = 1'b0;
        Ser      = 1'b0;
        SerValid = 1'b0;
        WordDone = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shreg_d  = fifo_rdata;
                    cnt_d    = '0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                Ser      = shreg_q[WIDTH-1];
                SerValid = 1'b1;
                shreg_d  = shreg_q << 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    WordDone = 1'b1;
                    cnt_d    = '0;
                    // Reload on the LSB edge keeps the stream gap-free.
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shreg_d  = fifo_rdata;
                    end else begin
                        state_d  = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_seqdec_byte_serializer.sv
// Randomized and directed bench for seqdec_byte_serializer against a
// queue-based word/bit reference model.
module tb_seqdec_byte_serializer;
    import seqdec_pkg::*;

    localparam int W = DEF_WIDTH;
    localparam int D = DEF_DEPTH;

    logic         Clk = 1'b0;
    logic         Reset;
    logic [W-1:0] Data;
    logic         Valid;
    logic         Ready;
    logic         Ser;
    logic         SerValid;
    logic         WordDone;
    logic [2:0]   Level;

    int checks = 0;
    int failures = 0;

    // Reference model: buffered words plus the word on the line.
    logic [7:0] mq[$];
    logic [7:0] cur;
    int         rem;
    bit         acc_last;

    int  run_len;
    int  max_run;
    int  wd_count;
    bit  rec_on;
    bit  obs_bits[$];

    always #5 Clk = ~Clk;

    seqdec_byte_serializer #(
        .WIDTH (W),
        .DEPTH (D)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Data     (Data),
        .Valid    (Valid),
        .Ready    (Ready),
        .Ser      (Ser),
        .SerValid (SerValid),
        .WordDone (WordDone),
        .Level    (Level)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outputs(input string tag);
        chk({tag, ".ready"}, 32'(Ready), 32'(mq.size() < D));
        chk({tag, ".level"}, 32'(Level), 32'(mq.size()));
        chk({tag, ".serv"}, 32'(SerValid), 32'(rem > 0));
        chk({tag, ".ser"}, 32'(Ser), (rem > 0) ? 32'(cur[rem-1]) : 32'd0);
        chk({tag, ".wdone"}, 32'(WordDone), 32'(rem == 1));
    endtask

    task automatic model_reset();
        mq.delete();
        cur = '0;
        rem = 0;
    endtask

    // One clock: check at the negedge, then advance the model at the posedge.
    task automatic cycle(input string tag);
        bit acc;
        chk_outputs(tag);
        if (SerValid) begin
            run_len++;
            if (run_len > max_run) max_run = run_len;
            if (rec_on) obs_bits.push_back(Ser);
        end else begin
            run_len = 0;
        end
        if (WordDone) wd_count++;
        acc = Valid && (mq.size() < D);
        @(posedge Clk);
        if (rem <= 1 && mq.size() > 0) begin
            cur = mq.pop_front();
            rem = W;
        end else if (rem > 0) begin
            rem--;
        end
        if (acc) mq.push_back(Data);
        acc_last = acc;
        @(negedge Clk);
    endtask

    task automatic push_word(input string tag, input logic [7:0] d);
        int n;
        Data  = d;
        Valid = 1'b1;
        n = 0;
        acc_last = 1'b0;
        while (!acc_last && n < 50) begin
            cycle(tag);
            n++;
        end
        if (!acc_last) chk({tag, ".push_timeout"}, 0, 1);
    endtask

    task automatic drain(input string tag, input int n);
        Valid = 1'b0;
        for (int i = 0; i < n; i++) cycle(tag);
    endtask

    function automatic int count_match(input bit b[$]);
        logic [7:0] sh;
        int c;
        sh = '0;
        c  = 0;
        for (int i = 0; i < b.size(); i++) begin
            sh = {sh[6:0], b[i]};
            if (i >= 7 && sh == MATCH_BYTE) c++;
        end
        return c;
    endfunction

    logic [7:0] stream_a [9] = '{8'h26, 8'hA3, 8'h52, 8'hF5, 8'h45,
                                 8'h97, 8'h93, 8'h45, 8'h78};
    logic [7:0] stream_b [16] = '{8'h00, 8'h26, 8'hA3, 8'h52, 8'hF5,
                                  8'h45, 8'h97, 8'h93, 8'h45, 8'h78,
                                  8'h26, 8'hA5, 8'h29, 8'h37, 8'h82,
                                  8'hAB};

    initial begin
        bit exp_bits[$];
        int n;
        Reset = 1'b1;
        Valid = 1'b0;
        Data  = '0;
        model_reset();
        run_len = 0; max_run = 0; wd_count = 0; rec_on = 0;

        // Reset values
        #3;
        chk_outputs("rst_hold");
        @(negedge Clk);
        Reset = 1'b0;
        drain("idle", 5);

        // Single word
        push_word("single", MATCH_BYTE);
        wd_count = 0;
        drain("single", 12);
        chk("single.wdcount", 32'(wd_count), 1);

        // Back-to-back stream
        max_run = 0; wd_count = 0;
        foreach (stream_a[i]) push_word("b2b", stream_a[i]);
        drain("b2b", 80);
        chk("b2b.run", 32'(max_run), 72);
        chk("b2b.wdcount", 32'(wd_count), 9);

        // Backpressure: six words while the first shifts
        wd_count = 0;
        for (int i = 0; i < 6; i++) push_word("bp", 8'(8'h10 + i));
        drain("bp", 60);
        chk("bp.wdcount", 32'(wd_count), 6);

        // Reset mid-word
        push_word("mid", 8'hAB);
        push_word("mid", 8'h11);
        push_word("mid", 8'h22);
        Valid = 1'b0;
        n = 0;
        while (rem != 5 && n < 20) begin
            cycle("mid");
            n++;
        end
        chk("mid.bits_out", 32'(rem), 5);
        chk("mid.level", 32'(Level), 2);
        #2 Reset = 1'b1;
        #1;
        model_reset();
        chk_outputs("mid_rst");
        @(negedge Clk);
        Reset = 1'b0;
        drain("post_rst", 3);
        push_word("post", 8'h26);
        drain("post", 12);

        // Randomized traffic with a producer that holds Data until taken
        Data  = 8'($urandom);
        Valid = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!Valid || acc_last) begin
                Data  = 8'($urandom);
                Valid = ($urandom_range(0, 3) != 0);
            end
            cycle("rand");
        end
        drain("rand", 50);

        // Integration stream: count match windows in the serial bits
        obs_bits.delete();
        rec_on = 1'b1;
        foreach (stream_b[i]) push_word("intg", stream_b[i]);
        drain("intg", 40);
        rec_on = 1'b0;
        foreach (stream_b[i])
            for (int b = 7; b >= 0; b--) exp_bits.push_back(stream_b[i][b]);
        chk("intg.nbits", 32'(obs_bits.size()), 128);
        chk("intg.matches", 32'(count_match(obs_bits)),
            32'(count_match(exp_bits)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
